// File: rtl/avalon_master_lsu.sv
// Avalon-MM initiator for the core load/store path: one request at a time, aligned bus cycle, extended load data.
// Optional stall timeout is compiled in when AVALON_TIMEOUT_EN is defined (limit set by TIMEOUT_CYCLES).
module avalon_master_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, RESP = 2'b10} state_t;

  state_t      state_r, state_nxt_s;
  logic [1:0]  size_r, size_nxt_s;
  logic [1:0]  lane_r, lane_nxt_s;
  logic        signed_r, signed_nxt_s;
  logic [31:0] address_nxt_s, writedata_nxt_s, resp_rdata_nxt_s;
  logic [3:0]  byteenable_nxt_s;
  logic        read_nxt_s, write_nxt_s, resp_valid_nxt_s, resp_error_nxt_s;
  logic        accept_s, tmo_hit_s;

  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = lane[0];
      2'b10:   req_bad = (lane != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   lane_enables = 4'b0001 << lane;
      2'b01:   lane_enables = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_enables = 4'b1111;
      default: lane_enables = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      2'b00:   lane_replicate = {4{wdata[7:0]}};
      2'b01:   lane_replicate = {2{wdata[15:0]}};
      default: lane_replicate = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic [1:0] lane,
                                               input logic sgn, input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{lane, 3'b000} +: 8];
    h = data[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_extract = {{24{sgn & b[7]}}, b};
      2'b01:   load_extract = {{16{sgn & h[15]}}, h};
      default: load_extract = data;
    endcase
  endfunction

  assign req_ready = (state_r == IDLE);
  assign accept_s  = (state_r == IDLE) && req_valid;

`ifdef AVALON_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  logic [CNT_W-1:0] tmo_cnt_r;

  // Stall counter: cleared when a request is taken, advanced on every stalled bus cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      tmo_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == BUS) && waitrequest) begin
      tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  assign tmo_hit_s = waitrequest && (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 32'd1));
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic; every register holds unless a transition updates it.
  always_comb begin
    state_nxt_s      = state_r;
    size_nxt_s       = size_r;
    lane_nxt_s       = lane_r;
    signed_nxt_s     = signed_r;
    address_nxt_s    = address;
    writedata_nxt_s  = writedata;
    byteenable_nxt_s = byteenable;
    read_nxt_s       = read;
    write_nxt_s      = write;
    resp_valid_nxt_s = 1'b0;
    resp_error_nxt_s = resp_error;
    resp_rdata_nxt_s = resp_rdata;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          size_nxt_s   = req_size;
          lane_nxt_s   = req_addr[1:0];
          signed_nxt_s = req_signed;
          if (req_bad(req_size, req_addr[1:0])) begin
            resp_valid_nxt_s = 1'b1;
            resp_error_nxt_s = 1'b1;
            resp_rdata_nxt_s = 32'h0000_0000;
            state_nxt_s      = RESP;
          end else begin
            address_nxt_s    = {req_addr[31:2], 2'b00};
            byteenable_nxt_s = lane_enables(req_size, req_addr[1:0]);
            writedata_nxt_s  = req_write ? lane_replicate(req_size, req_wdata) : 32'h0000_0000;
            read_nxt_s       = ~req_write;
            write_nxt_s      = req_write;
            state_nxt_s      = BUS;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          read_nxt_s       = 1'b0;
          write_nxt_s      = 1'b0;
          byteenable_nxt_s = 4'b0000;
          resp_valid_nxt_s = 1'b1;
          resp_error_nxt_s = 1'b0;
          resp_rdata_nxt_s = read ? load_extract(size_r, lane_r, signed_r, readdata) : 32'h0000_0000;
          state_nxt_s      = RESP;
        end else if (tmo_hit_s) begin
          read_nxt_s       = 1'b0;
          write_nxt_s      = 1'b0;
          byteenable_nxt_s = 4'b0000;
          resp_valid_nxt_s = 1'b1;
          resp_error_nxt_s = 1'b1;
          resp_rdata_nxt_s = 32'h0000_0000;
          state_nxt_s      = RESP;
        end else begin
          state_nxt_s = BUS;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        read_nxt_s       = 1'b0;
        write_nxt_s      = 1'b0;
        byteenable_nxt_s = 4'b0000;
        state_nxt_s      = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered request context, bus outputs and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      size_r     <= 2'b00;
      lane_r     <= 2'b00;
      signed_r   <= 1'b0;
      address    <= 32'h0000_0000;
      writedata  <= 32'h0000_0000;
      byteenable <= 4'b0000;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      size_r     <= size_nxt_s;
      lane_r     <= lane_nxt_s;
      signed_r   <= signed_nxt_s;
      address    <= address_nxt_s;
      writedata  <= writedata_nxt_s;
      byteenable <= byteenable_nxt_s;
      read       <= read_nxt_s;
      write      <= write_nxt_s;
      resp_valid <= resp_valid_nxt_s;
      resp_error <= resp_error_nxt_s;
      resp_rdata <= resp_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_avalon_master_lsu.sv
// Bench for avalon_master_lsu: expected responses are queued at issue time and checked by a monitor;
// a responder process injects wait states and read data and checks the bus fields.
`timescale 1ns/1ps
module tb_avalon_master_lsu;
  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        reset, req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_error, read, write, waitrequest;
  logic [31:0] resp_rdata, address, writedata, readdata;
  logic [3:0]  byteenable;

  avalon_master_lsu #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .address(address), .read(read), .write(write),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct { int unsigned cyc; logic [31:0] rdata; logic err; } resp_t;
  typedef struct { int unsigned waits; logic [31:0] rdata; logic wr; logic [31:0] addr;
                   logic [3:0] be; logic [31:0] wd; } bus_t;

  resp_t       sb_q[$];
  bus_t        bus_q[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on byte offsets.
  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1) return (addr % 32'd2) != 32'd0;
    if (size == 2'd2) return (addr % 32'd4) != 32'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] v;
    if (size == 2'd0)      v = 32'd1 << (addr % 32'd4);
    else if (size == 2'd1) v = 32'd3 << (addr & 32'd2);
    else                   v = 32'd15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic [31:0] addr,
                                         input logic sgn, input logic [31:0] rd);
    int unsigned shift;
    logic [31:0] mask, v;
    if (size == 2'd2) return rd;
    if (size == 2'd0) begin shift = 32'd8 * (addr % 32'd4); mask = 32'hFF; end
    else              begin shift = 32'd8 * (addr & 32'd2); mask = 32'hFFFF; end
    v = (rd >> shift) & mask;
    if (sgn && (v > (mask >> 1))) v = v - (mask + 32'd1);
    return v;
  endfunction

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wd, input int unsigned waits,
                       input logic [31:0] rd);
    resp_t e;
    bus_t  b;
    int    guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_signed = sgn; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 2000) begin @(negedge clk); guard++; end
    check("req_ready_wait", {31'h0, req_ready}, 32'h1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    e.err = m_err(size, addr);
    if (e.err) begin
      e.cyc = cyc + 32'd1; e.rdata = 32'h0;
    end else begin
      e.cyc   = cyc + 32'd2 + waits;
      e.rdata = wr ? 32'h0 : m_load(size, addr, sgn, rd);
`ifdef AVALON_TIMEOUT_EN
      if (waits >= TO_CYC) begin e.cyc = cyc + 32'd1 + TO_CYC; e.rdata = 32'h0; e.err = 1'b1; end
`endif
      b.waits = waits; b.rdata = rd; b.wr = wr; b.addr = addr & 32'hFFFF_FFFC;
      b.be = m_be(size, addr); b.wd = m_wd(size, wd);
      bus_q.push_back(b);
    end
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 3000) begin @(negedge clk); guard++; end
    check("drain_pending", sb_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Responder: applies queued wait states and read data, checks bus fields every active cycle.
  initial begin : responder
    bus_t        cur;
    bit          busy;
    int unsigned wleft;
    busy = 1'b0; wleft = 0;
    waitrequest = 1'b0; readdata = 32'h0;
    forever begin
      @(negedge clk);
      if (reset || (busy && !(read || write))) begin
        busy = 1'b0; wleft = 0; waitrequest = 1'b0;
      end else begin
        if ((read || write) && !busy) begin
          tests++;
          if (bus_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_bus: read=%b write=%b address=%h (cycle %0d)", read, write, address, cyc);
            cur.waits = 0; cur.rdata = 32'h0; cur.wr = write; cur.addr = address;
            cur.be = byteenable; cur.wd = writedata;
          end else begin
            cur = bus_q.pop_front();
          end
          busy = 1'b1; wleft = cur.waits; readdata = cur.rdata;
        end
        if (busy) begin
          check("bus_dir", {30'h0, read, write}, {30'h0, ~cur.wr, cur.wr});
          check("bus_addr", address, cur.addr);
          check("bus_be", {28'h0, byteenable}, {28'h0, cur.be});
          if (cur.wr) check("bus_wdata", writedata, cur.wd);
          if (wleft > 0) begin waitrequest = 1'b1; wleft--; end
          else begin waitrequest = 1'b0; busy = 1'b0; end
        end else begin
          waitrequest = 1'b0;
        end
      end
    end
  end

  // Monitor: pops one expectation per response pulse.
  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      check("rw_exclusive", {31'h0, read & write}, 32'h0);
      if (resp_valid) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_resp: rdata=%h error=%b (cycle %0d)", resp_rdata, resp_error, cyc);
        end else begin
          e = sb_q.pop_front();
          check("resp_cycle", cyc, e.cyc);
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_error", {31'h0, resp_error}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] a;
    logic [1:0]  s;
    int          guard;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_signed = 1'b0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_bus", {30'h0, read, write}, 32'h0);
    check("rst_resp", {30'h0, resp_valid, resp_error}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_be", {28'h0, byteenable}, 32'h0);
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b0;

    issue(1'b0, 32'hBFC0_0004, 2'b10, 1'b0, 32'h0, 0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_0013, 2'b00, 1'b1, 32'h0, 0, 32'h80FF_7F01);
    issue(1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0, 1, 32'h80FF_7F01);
    issue(1'b0, 32'h0000_0012, 2'b01, 1'b1, 32'h0, 0, 32'h80FF_7F01);
    issue(1'b1, 32'h0000_0006, 2'b01, 1'b0, 32'h1234_ABCD, 3, 32'h0);
    issue(1'b0, 32'h0000_0002, 2'b10, 1'b0, 32'h0, 0, 32'h1111_1111);
    issue(1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0, 0, 32'h2222_2222);
    issue(1'b0, 32'hFFFF_FFFC, 2'b10, 1'b1, 32'h0, 2, 32'h1234_5678);
    issue(1'b1, 32'h0000_0021, 2'b00, 1'b0, 32'hA5A5_A55A, 0, 32'h0);

    for (int i = 0; i < 250; i++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a = a & 32'hFFFF_FFFE;
        if (s == 2'd2) a = a & 32'hFFFF_FFFC;
      end
      issue(1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom,
            $urandom_range(0, 4), $urandom);
    end
    drain();

    // Reset while a load is stalled; the pending response must vanish.
    issue(1'b0, 32'h0000_0040, 2'b10, 1'b0, 32'h0, 1000, 32'h0000_0055);
    guard = 0;
    while (!read && guard < 20) begin @(negedge clk); guard++; end
    check("stall_read", {31'h0, read}, 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_read", {31'h0, read}, 32'h0);
    check("midrst_ready", {31'h0, req_ready}, 32'h1);
    check("midrst_resp", {31'h0, resp_valid}, 32'h0);
    sb_q.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'hBFC0_0004, 2'b10, 1'b0, 32'h0, 0, 32'hCAFE_F00D);
`ifdef AVALON_TIMEOUT_EN
    issue(1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 1000, 32'h0000_0001);
    issue(1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0, TO_CYC - 1, 32'h0000_0002);
`endif
    drain();
    check("bus_q_empty", bus_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/avalon_master_lsu.md
Name: avalon_master_lsu

Overview:
- Avalon-MM initiator (master) for the MIPS core's load/store path; it is the requester side of the memory interface used by the test memory models.
- Accepts one load/store request at a time from the core and converts it to a single Avalon read or write. Generates word-aligned address, byteenable and lane-replicated writedata.
- Honours waitrequest, then returns aligned, sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- TIMEOUT_CYCLES, 256: maximum cycles a transfer may stall on waitrequest. Used only when AVALON_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_signed  in  1  load sign-extends when 1
- req_wdata  in  32  store value, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  valid with resp_valid: misaligned, illegal size or timeout
- address  out  32  Avalon address, always req_addr with bits [1:0] = 00
- read  out  1  Avalon read strobe
- write  out  1  Avalon write strobe
- waitrequest  in  1  Avalon stall from responder
- writedata  out  32  Avalon write data
- byteenable  out  4  Avalon byte lanes; lane k = bits [8k+7:8k], little-endian
- readdata  in  32  Avalon read data, valid in the cycle waitrequest is 0

Behaviour:
- States: IDLE, BUS, RESP.
- Reset values:
  - State goes to IDLE.
  - read, write, resp_valid, resp_error = 0.
  - address, writedata, resp_rdata = 0.
  - byteenable = 0000.
  - req_ready = 1 (combinational from IDLE).
- IDLE, req_valid = 1:
  - Request fields are registered on that edge.
  - If size is 11, or a half request has addr[0] = 1, or a word request has addr[1:0] != 00: go to RESP with error = 1, and no bus cycle is issued.
  - Otherwise go to BUS, driving address, byteenable, writedata and read or write from registers.
- byteenable:
  - byte: 0001 << addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- writedata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- BUS:
  - read/write and all bus outputs are held stable while waitrequest = 1.
  - On the edge where waitrequest = 0, the transfer completes:
    - Capture readdata (loads).
    - Drop read/write to 0; byteenable goes to 0000.
    - Go to RESP.
- Load data extraction:
  - byte: select lane addr[1:0].
  - half: select lanes {addr[1],1}:{addr[1],0}.
  - word: all 32 bits.
  - Sign-extend if req_signed, else zero-extend.
  - req_signed is ignored for words.
- RESP:
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - resp_rdata and resp_error hold their value until the next response.
- Latency:
  - Request accepted at edge N; read/write high during cycle N+1.
  - With zero wait states, resp_valid is high in cycle N+2 and req_ready is high again in cycle N+3.
  - Each waitrequest cycle adds 1.
  - Error responses: resp_valid in cycle N+1.
- Never more than one outstanding transfer; read and write are never both 1.
- req_valid is ignored outside IDLE (req_ready = 0).
- Reset mid-operation: read/write drop at the next edge, the pending response is discarded (no resp_valid), and the state returns to IDLE.
- Address arithmetic is 32-bit; no wrap checking. 0xFFFFFFFC is legal.

Optional Feature:
- Macro AVALON_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle with waitrequest = 1.
  - When it reaches TIMEOUT_CYCLES, read/write drop at that edge and the block goes to RESP with resp_error = 1 and resp_rdata = 0.
- Undefined: the counter is absent; BUS waits indefinitely and TIMEOUT_CYCLES is unused.

Test Plan:
- Word load, addr 0xBFC00004, waitrequest 0, readdata 0xDEADBEEF:
  - read = 1, address 0xBFC00004, byteenable 1111 in cycle N+1.
  - resp_valid in N+2 with resp_rdata 0xDEADBEEF, resp_error = 0.
- Byte load, addr 0x00000013, readdata 0x80FF7F01:
  - byteenable 1000.
  - signed → resp_rdata 0xFFFFFF80; unsigned → 0x00000080.
  - Half load at 0x12, signed → 0xFFFF80FF.
- Half store, addr 0x00000006, wdata 0x1234ABCD, waitrequest high 3 cycles:
  - address 0x4, byteenable 1100, writedata 0xABCDABCD, write held 4 cycles.
  - resp_valid the cycle after waitrequest drops; resp_rdata 0.
- Word load, addr 0x00000002 (misaligned):
  - read/write never asserted; resp_valid in N+1 with resp_error = 1.
  - req_size 11 gives the same response.
- Reset pulsed in BUS with waitrequest stuck high:
  - read = 0 next cycle; no resp_valid; req_ready = 1.
  - A following word load completes normally.
- With AVALON_TIMEOUT_EN defined, TIMEOUT_CYCLES = 8, waitrequest stuck high:
  - read deasserts after 8 BUS cycles.
  - resp_valid with resp_error = 1, resp_rdata 0.
